dart_turn_ctrl: RTL and testbench
=================================

Name: dart_turn_ctrl

Overview:
- Turn/round scheduler for the two-player dart game.
- Sits between the decoded hit stream and the per-player score units.
  - Decides which player owns each throw.
  - Issues subtract requests to the shared scoring datapath over a req/ack handshake.
  - Counts throws per turn and rounds per game.
  - Declares game over, either on a zero score or on round-limit expiry.
- Drives the active-player select, the remaining-throws LEDs and the winner flags consumed by the display logic.

Parameters:
- THROWS, 3, throws per turn; remain_led width equals THROWS.
- MAX_ROUNDS, 10, rounds before a forced game end; one round = player 0 turn + player 1 turn.
- RW, 4, width of the round counter; must hold MAX_ROUNDS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begin game from IDLE
- hit_valid  in  1  one-cycle pulse, decoded dart hit
- hit_value  in  4  points of the hit; 0 = miss
- resume  in  1  one-cycle pulse, continue after a throw
- switch  in  1  one-cycle pulse, hand over to next player
- sub_req  out  1  subtract request to score unit
- sub_player  out  1  target score unit
- sub_value  out  4  points to subtract
- sub_ack  in  1  one-cycle completion from score unit
- sub_zero  in  1  valid with sub_ack; score reached 0
- sub_bust  in  1  valid with sub_ack; value exceeded score, score unchanged
- score0, score1  in  10 each  current scores, used for round-limit decision
- player  out  1  active player
- remain_led  out  THROWS  thermometer of throws left
- round  out  RW  current round, 1-based
- game_over  out  1  sticky end flag
- winner  out  1  valid when game_over
- tie  out  1  valid when game_over

Behaviour:
- Reset values: state IDLE; player 0; remain_led all ones; round 1; sub_req 0; sub_player 0; sub_value 0; game_over 0; winner 0; tie 0.
- Reset takes priority over every other input, in any state, including mid-handshake. An outstanding request is abandoned and sub_req drops on the next edge.
- States: IDLE, WAIT_HIT, SUB, HOLD, SWITCH, GAMEOVER.
- IDLE:
  - start -> WAIT_HIT.
  - All other inputs ignored.
- WAIT_HIT:
  - hit_valid at cycle N -> sub_req=1, sub_player=player, sub_value=hit_value registered at N+1; state SUB.
  - A miss (value 0) still issues a request and consumes a throw.
- SUB:
  - sub_req, sub_player and sub_value hold stable until sub_ack.
  - Ack at cycle M -> sub_req=0 at M+1, plus exactly one of:
    - sub_zero=1 -> GAMEOVER; winner=player, tie=0. sub_zero wins if sub_bust is also set.
    - sub_bust=1 -> remain_led forced to 0; state SWITCH.
    - Otherwise remain_led shifts right by one (111->011->001->000). If the result is 0 -> SWITCH, else HOLD.
  - hit_valid, resume and switch are ignored in SUB.
- HOLD:
  - resume -> WAIT_HIT.
  - hit_valid ignored, even in the same cycle as resume.
- SWITCH:
  - switch with player=1 and round=MAX_ROUNDS -> GAMEOVER.
    - Lower score wins.
    - Equal scores: tie=1, winner=0.
  - switch otherwise:
    - player toggles.
    - remain_led set to all ones.
    - round increments when player goes 1->0.
    - state -> WAIT_HIT.
  - resume and hit_valid ignored.
- GAMEOVER:
  - Sticky until reset; remain_led all ones; all inputs ignored.
- switch outside SWITCH is ignored.
- sub_ack outside SUB is ignored; no state change.
- round never wraps: at most MAX_ROUNDS.

Decomposition:
- Package dart_pkg:
  - state encoding constants.
  - default THROWS and MAX_ROUNDS.
  - remain_led FULL/EMPTY constants.
  - 10-bit score width.
- Sub-module dart_throw_counter: the remain_led shift register plus round counter, with load_full, shift, clear and round_inc controls.

Test Plan:
- Reset, start, hit value 3, ack with zero=0 and bust=0 -> sub_req high one cycle after hit, drops one cycle after ack, with sub_value=3 and sub_player=0; remain_led 111->011; state HOLD.
- Three hits each with resume and ack, then switch -> remain_led 011, 001, 000; player becomes 1; remain_led 111; round stays 1. A second switch sequence for player 1 -> player 0, round 2.
- Hit with ack carrying both sub_bust=1 and sub_zero=1 -> zero priority: GAMEOVER, winner=player, tie=0. Separately, bust only -> remain_led 000, state SWITCH.
- MAX_ROUNDS=2, play out to the final switch with score0=40, score1=40 -> game_over=1, tie=1, winner=0. Repeat with score1=35 -> winner=1, tie=0.
- Stray-input and reset cases:
  - In HOLD, hit_valid and resume in the same cycle -> no sub_req, state WAIT_HIT.
  - switch in HOLD -> ignored.
  - sub_ack in WAIT_HIT -> ignored.
  - reset asserted while sub_req=1 -> next cycle sub_req=0, state IDLE, round 1, player 0.

Source files
------------

// File: rtl/dart_pkg.sv
// Shared definitions for the dart game turn scheduler.
//   - FSM state encoding
//   - default throws-per-turn and round limit
//   - remain_led full/empty patterns for the default throw count
//   - score width used by the score units
package dart_pkg;

   localparam int DEF_THROWS     = 3;
   localparam int DEF_MAX_ROUNDS = 10;
   localparam int SCORE_W        = 10;

   localparam logic [DEF_THROWS-1:0] LED_FULL  = '1;
   localparam logic [DEF_THROWS-1:0] LED_EMPTY = '0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_HIT = 3'd1,
      ST_SUB      = 3'd2,
      ST_HOLD     = 3'd3,
      ST_SWITCH   = 3'd4,
      ST_GAMEOVER = 3'd5
   } state_t;

endpackage

// File: rtl/dart_throw_counter.sv
// Remaining-throws thermometer and round counter.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   load_full             : refill remain_led to all ones
//   shift                 : consume one throw (shift right)
//   clear                 : drop all remaining throws (bust)
//   round_inc             : advance round, saturating at MAX_ROUNDS
//   remain_led [THROWS]   : thermometer of throws left
//   round [RW]            : current round, 1-based
module dart_throw_counter
   import dart_pkg::*;
#(
   parameter int THROWS     = DEF_THROWS,
   parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
   parameter int RW         = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_full,
   input  logic              shift,
   input  logic              clear,
   input  logic              round_inc,
   output logic [THROWS-1:0] remain_led,
   output logic [RW-1:0]     round
);

   localparam logic [RW-1:0] ROUND_MAX = RW'(MAX_ROUNDS);
   localparam logic [RW-1:0] ROUND_ONE = RW'(1);

   logic [THROWS-1:0] led_q, led_d;
   logic [RW-1:0]     round_q, round_d;

   always_comb begin
      led_d   = led_q;
      round_d = round_q;
      // clear (bust) dominates; the controller never asserts more than one,
      // but the ordering keeps the behaviour defined if it ever did.
      if (clear)
         led_d = '0;
      else if (shift)
         led_d = led_q >> 1;
      else if (load_full)
         led_d = '1;
      if (round_inc && (round_q < ROUND_MAX))
         round_d = round_q + ROUND_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q   <= '1;
         round_q <= ROUND_ONE;
      end else begin
         led_q   <= led_d;
         round_q <= round_d;
      end
   end

   assign remain_led = led_q;
   assign round      = round_q;

endmodule

// File: rtl/dart_turn_ctrl.sv
// Turn/round scheduler for the two-player dart game.
// Owns each throw, issues subtract requests to the shared score unit over a
// req/ack handshake, counts throws and rounds, and declares game over on a
// zero score or on round-limit expiry.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start                      : begin game from IDLE
//   hit_valid, hit_value       : decoded dart hit (value 0 = miss)
//   resume, switch             : operator continue / hand-over pulses
//   sub_req/sub_player/sub_value : subtract request to score unit
//   sub_ack, sub_zero, sub_bust  : completion and result flags
//   score0, score1             : current scores for the round-limit decision
//   player, remain_led, round  : display state
//   game_over, winner, tie     : end-of-game flags
module dart_turn_ctrl
   import dart_pkg::*;
#(
   parameter int THROWS     = DEF_THROWS,
   parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
   parameter int RW         = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               hit_valid,
   input  logic [3:0]         hit_value,
   input  logic               resume,
   input  logic               switch,
   output logic               sub_req,
   output logic               sub_player,
   output logic [3:0]         sub_value,
   input  logic               sub_ack,
   input  logic               sub_zero,
   input  logic               sub_bust,
   input  logic [SCORE_W-1:0] score0,
   input  logic [SCORE_W-1:0] score1,
   output logic               player,
   output logic [THROWS-1:0]  remain_led,
   output logic [RW-1:0]      round,
   output logic               game_over,
   output logic               winner,
   output logic               tie
);

   localparam logic [RW-1:0] ROUND_MAX = RW'(MAX_ROUNDS);

   state_t     state_q, state_d;
   logic       sub_req_q, sub_req_d;
   logic       sub_player_q, sub_player_d;
   logic [3:0] sub_value_q, sub_value_d;
   logic       player_q, player_d;
   logic       game_over_q, game_over_d;
   logic       winner_q, winner_d;
   logic       tie_q, tie_d;

   logic load_full, shift, clear, round_inc;

   dart_throw_counter #(
      .THROWS     (THROWS),
      .MAX_ROUNDS (MAX_ROUNDS),
      .RW         (RW)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_full  (load_full),
      .shift      (shift),
      .clear      (clear),
      .round_inc  (round_inc),
      .remain_led (remain_led),
      .round      (round)
   );

   always_comb begin
      state_d      = state_q;
      sub_req_d    = sub_req_q;
      sub_player_d = sub_player_q;
      sub_value_d  = sub_value_q;
      player_d     = player_q;
      game_over_d  = game_over_q;
      winner_d     = winner_q;
      tie_d        = tie_q;
      load_full    = 1'b0;
      shift        = 1'b0;
      clear        = 1'b0;
      round_inc    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_WAIT_HIT;
         end

         ST_WAIT_HIT: begin
            // Misses still go through the score unit so every throw costs
            // one handshake and one LED.
            if (hit_valid) begin
               sub_req_d    = 1'b1;
               sub_player_d = player_q;
               sub_value_d  = hit_value;
               state_d      = ST_SUB;
            end
         end

         ST_SUB: begin
            if (sub_ack) begin
               sub_req_d = 1'b0;
               if (sub_zero) begin
                  // A checkout beats a simultaneous bust flag.
                  game_over_d = 1'b1;
                  winner_d    = player_q;
                  tie_d       = 1'b0;
                  load_full   = 1'b1;
                  state_d     = ST_GAMEOVER;
               end else if (sub_bust) begin
                  clear   = 1'b1;
                  state_d = ST_SWITCH;
               end else begin
                  shift   = 1'b1;
                  state_d = ((remain_led >> 1) == '0) ? ST_SWITCH : ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (resume) state_d = ST_WAIT_HIT;
         end

         ST_SWITCH: begin
            if (switch) begin
               load_full = 1'b1;
               if (player_q && (round == ROUND_MAX)) begin
                  // Round limit: lower remaining score wins.
                  game_over_d = 1'b1;
                  tie_d       = (score0 == score1);
                  winner_d    = (score1 < score0);
                  state_d     = ST_GAMEOVER;
               end else begin
                  round_inc = player_q;
                  player_d  = ~player_q;
                  state_d   = ST_WAIT_HIT;
               end
            end
         end

         ST_GAMEOVER: ;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sub_req_q    <= 1'b0;
         sub_player_q <= 1'b0;
         sub_value_q  <= 4'd0;
         player_q     <= 1'b0;
         game_over_q  <= 1'b0;
         winner_q     <= 1'b0;
         tie_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sub_req_q    <= sub_req_d;
         sub_player_q <= sub_player_d;
         sub_value_q  <= sub_value_d;
         player_q     <= player_d;
         game_over_q  <= game_over_d;
         winner_q     <= winner_d;
         tie_q        <= tie_d;
      end
   end

   assign sub_req    = sub_req_q;
   assign sub_player = sub_player_q;
   assign sub_value  = sub_value_q;
   assign player     = player_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign tie        = tie_q;

endmodule

// File: tb/tb_dart_turn_ctrl.sv
// Bench for dart_turn_ctrl: directed scenarios followed by random games,
// all checked against a throw/turn-level model of the game rules.
module tb_dart_turn_ctrl;

   localparam int THROWS = 3;
   localparam int MAXR   = 2;
   localparam int RW     = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0, start = 1'b0, hit_valid = 1'b0;
   logic [3:0]        hit_value = 4'd0;
   logic              resume = 1'b0, switch = 1'b0;
   logic              sub_req, sub_player;
   logic [3:0]        sub_value;
   logic              sub_ack = 1'b0, sub_zero = 1'b0, sub_bust = 1'b0;
   logic [9:0]        score0 = 10'd0, score1 = 10'd0;
   logic              player, game_over, winner, tie;
   logic [THROWS-1:0] remain_led;
   logic [RW-1:0]     round;

   dart_turn_ctrl #(.THROWS(THROWS), .MAX_ROUNDS(MAXR), .RW(RW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .hit_valid(hit_valid), .hit_value(hit_value),
      .resume(resume), .switch(switch),
      .sub_req(sub_req), .sub_player(sub_player), .sub_value(sub_value),
      .sub_ack(sub_ack), .sub_zero(sub_zero), .sub_bust(sub_bust),
      .score0(score0), .score1(score1),
      .player(player), .remain_led(remain_led), .round(round),
      .game_over(game_over), .winner(winner), .tie(tie)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Game model: whose turn, throws left, round, and end result.
   int m_player, m_left, m_round;
   int m_over, m_win, m_tie;

   function automatic logic [31:0] therm(input int n);
      return 32'((1 << n) - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int exp_req);
      chk({tag, ".sub_req"},    32'(sub_req),    32'(exp_req));
      chk({tag, ".player"},     32'(player),     32'(m_player));
      chk({tag, ".remain_led"}, 32'(remain_led), therm(m_left));
      chk({tag, ".round"},      32'(round),      32'(m_round));
      chk({tag, ".game_over"},  32'(game_over),  32'(m_over));
      chk({tag, ".winner"},     32'(winner),     32'(m_win));
      chk({tag, ".tie"},        32'(tie),        32'(m_tie));
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_player = 0; m_left = THROWS; m_round = 1;
      m_over = 0; m_win = 0; m_tie = 0;
      check_all(tag, 0);
      chk({tag, ".sub_player"}, 32'(sub_player), 32'd0);
      chk({tag, ".sub_value"},  32'(sub_value),  32'd0);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_resume(input string tag);
      resume = 1'b1;
      step();
      resume = 1'b0;
      check_all(tag, 0);
   endtask

   // One throw: hit, request checks while waiting, then ack with flags.
   // Stray hit/resume/switch while the request is open must not disturb it.
   task automatic throw(input string tag, input int v, input int z, input int b, input int dly);
      hit_valid = 1'b1; hit_value = 4'(v);
      step();
      hit_valid = 1'b0;
      chk({tag, ".req_on"}, 32'(sub_req),    32'd1);
      chk({tag, ".splayer"}, 32'(sub_player), 32'(m_player));
      chk({tag, ".svalue"},  32'(sub_value),  32'(v));
      for (int i = 0; i < dly; i++) begin
         if ($urandom_range(1) == 1) begin
            hit_valid = 1'b1; hit_value = 4'(~v); resume = 1'b1; switch = 1'b1;
         end
         step();
         hit_valid = 1'b0; resume = 1'b0; switch = 1'b0;
         chk({tag, ".req_hold"},   32'(sub_req),   32'd1);
         chk({tag, ".value_hold"}, 32'(sub_value), 32'(v));
         chk({tag, ".left_hold"},  32'(remain_led), therm(m_left));
      end
      sub_ack = 1'b1; sub_zero = 1'(z); sub_bust = 1'(b);
      step();
      sub_ack = 1'b0; sub_zero = 1'b0; sub_bust = 1'b0;
      if (z != 0) begin
         m_over = 1; m_win = m_player; m_tie = 0; m_left = THROWS;
      end else if (b != 0) begin
         m_left = 0;
      end else begin
         m_left = m_left - 1;
      end
      check_all({tag, ".ack"}, 0);
   endtask

   // Hand-over only takes effect once a turn has run out of throws.
   task automatic do_switch(input string tag);
      switch = 1'b1;
      step();
      switch = 1'b0;
      if (m_left == 0 && m_over == 0) begin
         m_left = THROWS;
         if (m_player == 1 && m_round == MAXR) begin
            m_over = 1;
            m_tie  = (score0 == score1) ? 1 : 0;
            m_win  = (score1 < score0) ? 1 : 0;
         end else begin
            if (m_player == 1) m_round++;
            m_player = 1 - m_player;
         end
      end
      check_all(tag, 0);
   endtask

   initial begin
      // Reset and the first throw
      do_reset("rst");
      do_start();
      check_all("start", 0);
      throw("t1", 3, 0, 0, 2);
      // switch in HOLD is ignored
      do_switch("sw_hold");
      // hit and resume together in HOLD: resume taken, hit dropped
      hit_valid = 1'b1; hit_value = 4'd5; resume = 1'b1;
      step();
      hit_valid = 1'b0; resume = 1'b0;
      chk("hold_hit.req0", 32'(sub_req), 32'd0);
      step();
      chk("hold_hit.req1", 32'(sub_req), 32'd0);
      // ack in WAIT_HIT is ignored
      sub_ack = 1'b1; sub_zero = 1'b1;
      step();
      sub_ack = 1'b0; sub_zero = 1'b0;
      check_all("stray_ack", 0);
      throw("t2", 0, 0, 0, 0);
      do_resume("r2");
      throw("t3", 7, 0, 0, 1);
      do_switch("sw_p1");
      throw("p1t1", 1, 0, 0, 0); do_resume("p1r1");
      throw("p1t2", 2, 0, 0, 0); do_resume("p1r2");
      throw("p1t3", 4, 0, 0, 0);
      do_switch("sw_r2");
      // Bust ends the turn
      throw("bust", 5, 0, 1, 1);
      do_switch("sw_bust");
      // Final turn: equal scores tie
      throw("f1", 2, 0, 0, 0); do_resume("fr1");
      throw("f2", 2, 0, 0, 0); do_resume("fr2");
      throw("f3", 2, 0, 0, 0);
      score0 = 10'd40; score1 = 10'd40;
      do_switch("tie_end");
      // GAMEOVER ignores everything
      start = 1'b1; hit_valid = 1'b1; resume = 1'b1; switch = 1'b1; sub_ack = 1'b1;
      step();
      start = 1'b0; hit_valid = 1'b0; resume = 1'b0; switch = 1'b0; sub_ack = 1'b0;
      check_all("over_sticky", 0);

      // Round-limit with player 1 lower
      do_reset("rst2");
      do_start();
      for (int t = 0; t < 2 * MAXR; t++) begin
         throw("lim", 6, 0, 1, 0);
         if (t == 2 * MAXR - 1) begin
            score0 = 10'd40; score1 = 10'd35;
         end
         do_switch("lim_sw");
      end

      // Zero beats bust, winner is the thrower
      do_reset("rst3");
      do_start();
      throw("zb_pre", 9, 0, 1, 0);
      do_switch("zb_sw");
      throw("zb", 9, 1, 1, 1);

      // Reset while a request is open
      do_reset("rst4");
      do_start();
      hit_valid = 1'b1; hit_value = 4'd11;
      step();
      hit_valid = 1'b0;
      chk("mid.req", 32'(sub_req), 32'd1);
      do_reset("mid_rst");

      // Random games
      for (int g = 0; g < 25; g++) begin
         do_reset("g_rst");
         do_start();
         for (int a = 0; a < 40 && m_over == 0; a++) begin
            throw("g_thr", int'($urandom_range(15)),
                  ($urandom_range(19) == 0) ? 1 : 0,
                  ($urandom_range(5) == 0) ? 1 : 0,
                  int'($urandom_range(3)));
            if (m_over != 0) break;
            if (m_left == 0) begin
               score0 = 10'($urandom_range(60));
               score1 = ($urandom_range(3) == 0) ? score0 : 10'($urandom_range(60));
               do_switch("g_sw");
            end else begin
               if ($urandom_range(2) == 0) do_switch("g_stray_sw");
               do_resume("g_res");
            end
         end
         chk("g_over", 32'(game_over), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
